seq_shift_rotate: RTL
=====================

SEQ_SHIFT_ROTATE -- requirements
Module: seq_shift_rotate

Interface
REQ-001 The block SHALL use reset rst_a, asynchronous, active-high, and clock clk.
REQ-002 Parameter WIDTH, 64, datapath width; SHALL be a power of two, at least 2.
REQ-003 Parameter STEP, 8, maximum bit positions shifted per cycle; SHALL satisfy 1 <= STEP <= WIDTH.
REQ-004 Derived AW = $clog2(WIDTH) SHALL size the amount field.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_a  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  request offered.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 in_data  input  WIDTH  operand.
REQ-010 in_amt  input  AW  shift/rotate distance, 0..WIDTH-1.
REQ-011 in_mode  input  3  000 LSL, 001 LSR, 010 ROL, 011 ROR, 100 ASR; 101-111 illegal.
REQ-012 abort  input  1  synchronous cancel of an in-flight operation.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 out_data  output  WIDTH  result.
REQ-016 out_err  output  1  result came from an illegal mode; qualified by out_valid.
REQ-017 busy  output  1  high in SHIFT state.

Function
REQ-018 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge.
REQ-020 On accept: capture in_data, in_amt (as remaining count), in_mode; next state SHIFT if amt != 0 and mode legal, else DONE.
REQ-021 SHIFT: each cycle shift working register by s = min(remaining, STEP), remaining -= s; go DONE when remaining reaches 0.
REQ-022 Latency: out_valid SHALL be high after edge E0+N, E0 = accept edge, N = ceil(amt/STEP); N = 0 for amt 0 or illegal mode.
REQ-023 LSL/LSR SHALL zero-fill; ASR SHALL replicate the captured MSB; ROL/ROR SHALL wrap bits end-around without loss.
REQ-024 amt = 0 SHALL return in_data unchanged, out_err = 0.
REQ-025 Illegal mode SHALL return in_data unchanged with out_err = 1.
REQ-026 DONE: out_valid = 1; out_data/out_err held stable until out_valid & out_ready, then IDLE.
REQ-027 No new request SHALL be accepted in the transfer cycle; next accept is possible at the following edge at the earliest.
REQ-028 abort in SHIFT SHALL discard the operation and go to IDLE at that edge, with no out_valid.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 Input changes while not in IDLE SHALL have no effect on the in-flight operation.

Reset
REQ-031 rst_a SHALL immediately force IDLE, in_ready = 1, out_valid = 0, busy = 0, out_err = 0, out_data = 0, remaining = 0, including mid-SHIFT or mid-DONE.
REQ-032 After rst_a deasserts, the first accept SHALL behave identically to one from power-up.

Verification (WIDTH=64, STEP=8)
REQ-033 LSL, data 0x1, amt 9 -> busy for 2 cycles, out_data 0x200, out_valid after E0+2.
REQ-034 ROR, data 0x1, amt 1 -> out_data 0x8000_0000_0000_0000 after E0+1; ROL of 0xF000_0000_0000_0001 by 4 -> 0x0000_0000_0000_001F.
REQ-035 ASR, data 0x8000_0000_0000_0000, amt 63 -> out_data 0xFFFF_FFFF_FFFF_FFFF after E0+8; LSR of the same data, amt 63 -> 0x1.
REQ-036 out_ready held low 5 cycles in DONE -> out_data and out_valid stable, in_ready = 0 throughout; accept resumes after transfer.
REQ-037 mode 101, data 0xA5 -> out_valid after E0+0, out_err = 1, out_data 0xA5; amt 0 with LSL -> out_err = 0, data unchanged.
REQ-038 rst_a pulse mid-SHIFT (amt 40) and abort mid-SHIFT -> IDLE, no out_valid, next request (LSL 0x1 by 1) -> 0x2.

Source files
------------

// File: rtl/seq_shift_rotate.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_rotate
// Description : Multi-cycle shifter/rotator (LSL, LSR, ROL, ROR, ASR) moving
//               at most STEP bit positions per clock, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_rotate #(
   parameter  int WIDTH = 64,
   parameter  int STEP  = 8,
   localparam int AW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_a,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW-1:0]    in_amt,
   input  logic [2:0]       in_mode,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [2:0]  C_MODE_LSL = 3'b000;
   localparam logic [2:0]  C_MODE_LSR = 3'b001;
   localparam logic [2:0]  C_MODE_ROL = 3'b010;
   localparam logic [2:0]  C_MODE_ROR = 3'b011;
   localparam logic [2:0]  C_MODE_ASR = 3'b100;
   // One extra bit so both STEP == WIDTH and the wrap distance WIDTH - s fit.
   localparam logic [AW:0] C_STEP     = (AW+1)'(STEP);
   localparam logic [AW:0] C_WIDTH    = (AW+1)'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [AW-1:0]    rem_q,   rem_d;
   logic [2:0]       mode_q,  mode_d;
   logic             err_q,   err_d;

   logic [AW:0]      w_step_amt;
   logic [AW:0]      w_wrap_amt;
   logic [WIDTH-1:0] w_shifted;
   logic             w_in_illegal;

   assign w_in_illegal = (in_mode > C_MODE_ASR);

   // Distance moved this cycle: the remaining count, capped at STEP.
   always_comb begin
      w_step_amt = C_STEP;
      if ({1'b0, rem_q} < C_STEP) begin
         w_step_amt = {1'b0, rem_q};
      end
      w_wrap_amt = C_WIDTH - w_step_amt;
   end

   // Iterating arithmetic shifts keeps replicating the captured MSB, since the
   // sign bit of the working register never changes under ASR.
   always_comb begin
      w_shifted = data_q;
      case (mode_q)
         C_MODE_LSL: w_shifted = data_q << w_step_amt;
         C_MODE_LSR: w_shifted = data_q >> w_step_amt;
         C_MODE_ROL: w_shifted = (data_q << w_step_amt) | (data_q >> w_wrap_amt);
         C_MODE_ROR: w_shifted = (data_q >> w_step_amt) | (data_q << w_wrap_amt);
         C_MODE_ASR: w_shifted = WIDTH'($signed(data_q) >>> w_step_amt);
         default:    w_shifted = data_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d = in_data;
               mode_d = in_mode;
               err_d  = w_in_illegal;
               if (w_in_illegal || (in_amt == '0)) begin
                  rem_d   = '0;
                  state_d = S_DONE;
               end else begin
                  rem_d   = in_amt;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            if (abort) begin
               rem_d   = '0;
               state_d = S_IDLE;
            end else begin
               data_d = w_shifted;
               rem_d  = rem_q - w_step_amt[AW-1:0];
               if ({1'b0, rem_q} == w_step_amt) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         mode_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_SHIFT);
   assign out_valid = (state_q == S_DONE);
   assign out_data  = data_q;
   assign out_err   = err_q;

endmodule
`default_nettype wire
